// File: rtl/cpu_common_pkg.sv
// cpu_common: shared prefetch state and queue entry types
package cpu_common;
  localparam int PC_MAX_W = 16;
  typedef enum logic [1:0] {ALIGNED, PRIME, UNALIGNED} prefetch_state_t;
  typedef struct packed {
    logic [15:0]         inst;
    logic [PC_MAX_W-1:0] pc;
  } prefetch_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry circular instruction queue with single-cycle flush
module prefetch_fifo
  import cpu_common::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_async,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  prefetch_entry_t din,
  output logic [CW-1:0]   count,
  output logic            valid,
  output prefetch_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  prefetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign do_push = push & !flush;
  assign do_pop = pop & valid & !flush;
  assign head = valid ? mem[rd_ptr] : '0;
  // pointers and occupancy; flush empties the queue at once
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: sequential instruction prefetch with redirect; PREFETCH_UNALIGNED_EN adds odd-PC byte stitching
module prefetch_unit
  import cpu_common::*;
#(
  parameter int PC_W = 14,
  parameter int DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_async,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [15:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            mem_inst_rd,
  output logic [PC_W-2:0] mem_inst_addr,
  input  logic [15:0]     mem_instr
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  logic [PC_W-2:0] faddr;
  logic [PC_W-1:0] epc, tgt;
  logic inflight, push, pop, q_valid, issue, unused_pc;
  logic [CW-1:0] count;
  prefetch_entry_t din, head;
`ifdef PREFETCH_UNALIGNED_EN
  localparam logic [PC_W-1:0] START_PC = RESET_PC;
  prefetch_state_t state, state_n;
  logic [7:0] leftover;
  assign tgt = redirect_pc;
  assign push = inflight & !redirect_valid & (state != PRIME);
  assign din = '{inst: state == UNALIGNED ? {leftover, mem_instr[15:8]} : mem_instr, pc: PC_MAX_W'(epc)};
  assign unused_pc = ^head.pc;
  // priming word only seeds the leftover byte, then every word completes one instruction
  always_comb
    state_n = redirect_valid ? (tgt[0] ? PRIME : ALIGNED) : (inflight && state == PRIME) ? UNALIGNED : state;
  // alignment state and the byte carried across word boundaries
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      state <= START_PC[0] ? PRIME : ALIGNED;
      leftover <= '0;
    end else begin
      state <= state_n;
      if (inflight && !redirect_valid && state != ALIGNED) leftover <= mem_instr[7:0];
    end
`else
  localparam logic [PC_W-1:0] START_PC = {RESET_PC[PC_W-1:1], 1'b0};
  assign tgt = {redirect_pc[PC_W-1:1], 1'b0};
  assign push = inflight & !redirect_valid;
  assign din = '{inst: mem_instr, pc: PC_MAX_W'(epc)};
  assign unused_pc = redirect_pc[0] ^ (^head.pc);
`endif
  assign pop = q_valid & inst_ready & !redirect_valid;
  assign issue = fetch_en & !redirect_valid &
    ((CW + 1)'(count) + (CW + 1)'(inflight) < DEPTH_C + (CW + 1)'(pop));
  assign mem_inst_rd = issue & !rst_async;
  assign mem_inst_addr = mem_inst_rd ? faddr : '0;
  assign inst_valid = q_valid;
  assign inst = head.inst;
  assign inst_pc = head.pc[PC_W-1:0];
  // fetch word address, PC of next enqueued instruction, and in-flight read; redirect wins
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      faddr <= START_PC[PC_W-1:1];
      epc <= START_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      faddr <= tgt[PC_W-1:1];
      epc <= tgt;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) faddr <= faddr + (PC_W - 1)'(1);
      if (push) epc <= epc + PC_W'(2);
    end
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_async(rst_async),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .count(count),
    .valid(q_valid),
    .head(head)
  );
endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed and randomized check of prefetch_unit against an instruction-stream model
`timescale 1ns/1ps
module tb_prefetch_unit;
  localparam int DEPTH = 2;
  localparam logic [13:0] RESET_PC = 14'h0000;
  logic clk = 1'b0, rst_async = 1'b1, fetch_en = 1'b1, redirect_valid = 1'b0, inst_ready = 1'b1;
  logic [13:0] redirect_pc = '0;
  logic inst_valid, mem_inst_rd;
  logic [15:0] inst;
  logic [15:0] mem_instr = '0;
  logic [13:0] inst_pc;
  logic [12:0] mem_inst_addr;
  logic [15:0] mem [8192];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int arr, pops, pend, prime;
  logic [13:0] exp_pc;
  logic [12:0] exp_fa;

  prefetch_unit #(.PC_W(14), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_async(rst_async), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .mem_inst_rd(mem_inst_rd), .mem_inst_addr(mem_inst_addr), .mem_instr(mem_instr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_instr <= mem_inst_rd ? mem[mem_inst_addr] : 16'($urandom);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_inst(input logic [13:0] pc);
    logic [12:0] w;
    w = pc[13:1];
    return pc[0] ? {mem[w][7:0], mem[w + 13'd1][15:8]} : mem[w];
  endfunction

  function automatic logic [13:0] eff_pc(input logic [13:0] p);
`ifdef PREFETCH_UNALIGNED_EN
    return p;
`else
    return {p[13:1], 1'b0};
`endif
  endfunction

  // per-cycle compare: queue occupancy, issue rule, head contents and read addresses
  always @(negedge clk) begin
    int occ, fire;
    logic [13:0] t;
    if (rst_async) begin
      chk("rst_valid", inst_valid, 0);
      chk("rst_rd", mem_inst_rd, 0);
      chk("rst_addr", mem_inst_addr, 0);
      chk("rst_inst", inst, 0);
      chk("rst_pc", inst_pc, 0);
      exp_pc = eff_pc(RESET_PC);
      exp_fa = RESET_PC[13:1];
      arr = 0; pops = 0; pend = 0; prime = int'(eff_pc(RESET_PC) & 14'd1);
    end else begin
      occ = (arr > prime ? arr - prime : 0) - pops;
      fire = (occ > 0 && inst_ready && !redirect_valid) ? 1 : 0;
      chk("valid", inst_valid, occ > 0);
      chk("rd", mem_inst_rd, fetch_en && !redirect_valid && (occ + pend - fire < DEPTH));
      if (occ > 0) begin
        chk("inst", inst, model_inst(exp_pc));
        chk("inst_pc", inst_pc, exp_pc);
      end else begin
        chk("empty_inst", inst, 0);
        chk("empty_pc", inst_pc, 0);
      end
      if (mem_inst_rd) begin
        chk("addr", mem_inst_addr, exp_fa);
        exp_fa = exp_fa + 13'd1;
      end
      if (fire != 0) begin
        exp_pc = exp_pc + 14'd2;
        pops++;
      end
      arr += pend;
      pend = mem_inst_rd ? 1 : 0;
      if (redirect_valid) begin
        t = eff_pc(redirect_pc);
        exp_pc = t; exp_fa = t[13:1];
        arr = 0; pops = 0; pend = 0; prime = int'(t[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [13:0] pc, output int t0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = pc;
    t0 = cyc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input int t0, output int lat);
    int n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) chk("wait_valid_timeout", inst_valid, 1);
    lat = cyc - t0;
  endtask

  initial begin
    int lat, t0, n;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    mem[8] = 16'hAABB;
    mem[9] = 16'hCCDD;
    mem[13'h80] = 16'hBEEF;
    mem[13'h1FFF] = 16'h1234;
    repeat (3) step();
    rst_async = 1'b0;
    @(negedge clk);
    chk("first_rd", mem_inst_rd, 1);
    chk("first_addr", mem_inst_addr, 0);
    step(); @(negedge clk);
    chk("first_valid_early", inst_valid, 0);
    step(); @(negedge clk);
    chk("first_valid", inst_valid, 1);
    chk("first_inst", inst, 16'h0000);
    chk("first_pc", inst_pc, 14'h0000);
    step(); @(negedge clk);
    chk("second_inst", inst, 16'h0001);
    chk("second_pc", inst_pc, 14'h0002);

    redirect(14'h0011, t0);
    @(negedge clk);
    chk("redir_rd", mem_inst_rd, 1);
    chk("redir_addr", mem_inst_addr, 13'h0008);
    wait_valid(t0, lat);
`ifdef PREFETCH_UNALIGNED_EN
    chk("odd_lat", lat, 4);
    chk("odd_inst", inst, 16'hBBCC);
    chk("odd_pc", inst_pc, 14'h0011);
`else
    chk("forced_even_lat", lat, 3);
    chk("forced_even_inst", inst, 16'hAABB);
    chk("forced_even_pc", inst_pc, 14'h0010);
`endif

    step();
    inst_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 4 && mem_inst_rd) n++;
      step();
    end
    chk("stall_rd_stopped", n, 0);
    chk("stall_held_valid", inst_valid, 1);
    inst_ready = 1'b1;
    repeat (5) step();

    @(negedge clk);
    chk("pre_redir_busy", mem_inst_rd & inst_valid, 1);
    redirect(14'h0100, t0);
    @(negedge clk);
    wait_valid(t0, lat);
    chk("flush_lat", lat, 3);
    chk("flush_inst", inst, 16'hBEEF);
    chk("flush_pc", inst_pc, 14'h0100);

    step();
    rst_async = 1'b1;
    mem[0] = 16'h5678;
    step(); step();
    rst_async = 1'b0;
    redirect(14'h3FFF, t0);
    @(negedge clk);
    chk("wrap_addr", mem_inst_addr, 13'h1FFF);
    wait_valid(t0, lat);
`ifdef PREFETCH_UNALIGNED_EN
    chk("wrap_inst", inst, 16'h3456);
    chk("wrap_pc", inst_pc, 14'h3FFF);
    step(); @(negedge clk);
    chk("wrap_next_pc", inst_pc, 14'h0001);
    chk("wrap_next_inst", inst, 16'h7800);
`else
    chk("wrap_inst", inst, 16'h1234);
    chk("wrap_pc", inst_pc, 14'h3FFE);
    step(); @(negedge clk);
    chk("wrap_next_pc", inst_pc, 14'h0000);
    chk("wrap_next_inst", inst, 16'h5678);
`endif

    step();
    rst_async = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    step();
    rst_async = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst_async) rst_async = 1'b0;
      else if ($urandom_range(0, 599) == 0) begin
        rst_async = 1'b1;
        redirect_valid = 1'b0;
        continue;
      end
      fetch_en = $urandom_range(0, 9) != 0;
      inst_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 24) == 0;
      redirect_pc = 14'($urandom);
    end
    step();
    rst_async = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetch unit for the CPU, sitting between the 16-bit instruction memory port and decode. Holds its own fetch PC, issues sequential word reads each cycle into a small instruction queue, supports byte-aligned (odd) PCs by stitching bytes across word boundaries, and restarts on redirects (jumps, calls, returns, interrupts). Presents instructions to decode with a valid/ready handshake.

## Interface
Parameters:
- PC_W, 14, byte-address width of PC; memory word address is PC_W-1 bits
- DEPTH, 2, instruction queue entries; power of two, >= 2
- RESET_PC, 0, fetch PC loaded on reset

Ports:
- clk  in  1  clock
- rst_async  in  1  asynchronous active-high reset
- fetch_en  in  1  allow new memory reads; queued data still drains when low
- redirect_valid  in  1  load redirect_pc, flush queue and in-flight read
- redirect_pc  in  PC_W  new byte PC
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst  out  16  head instruction
- inst_pc  out  PC_W  byte PC of head instruction
- mem_inst_rd  out  1  read strobe
- mem_inst_addr  out  PC_W-1  word address
- mem_instr  in  16  read data, valid exactly 1 cycle after strobe

## Operation
- Byte order: even byte = mem_instr[15:8]. Aligned instruction = word. Odd PC instruction = {word_k[7:0], word_k+1[15:8]}.
- States: ALIGNED (fetch PC even), PRIME (odd, leftover byte empty), UNALIGNED (odd, leftover byte held).
- ALIGNED: each returned word enqueued with its PC; fetch PC += 2.
- PRIME: first read returns word_k; low byte stored as leftover, nothing enqueued; -> UNALIGNED.
- UNALIGNED: each returned word enqueues {leftover, word[15:8]}; leftover <= word[7:0].
- Issue rule: mem_inst_rd = fetch_en & !redirect_valid & (PRIME issue or queue count + in-flight < DEPTH). At most one read in flight per cycle; sustained 1 instruction/cycle.
- Redirect (highest priority): queue flushed, in-flight data discarded, fetch PC <= redirect_pc, state <= ALIGNED if redirect_pc[0]==0 else PRIME. Simultaneous pop ignored. Redirect during PRIME/UNALIGNED discards leftover.
- Pop: inst_valid & inst_ready removes head; pop and enqueue same cycle allowed at full.
- Wrap-around: PC and word address wrap modulo 2^PC_W; odd PC 2^PC_W-1 stitches with word 0.
- inst/inst_pc driven 0 when queue empty (never X).
- Reset mid-operation: all state cleared immediately; in-flight data ignored.

## Timing
- Reset values: inst_valid 0, inst 0, inst_pc 0, mem_inst_rd 0, mem_inst_addr 0; queue empty; fetch PC RESET_PC; state from RESET_PC[0].
- Redirect at cycle t, aligned target: mem_inst_addr = target[PC_W-1:1] with strobe in t+1, inst_valid at t+3.
- Odd target: reads in t+1, t+2; inst_valid at t+4.
- Subsequent instructions 1/cycle with inst_ready held high.
- First fetch after reset release (fetch_en high) behaves as redirect to RESET_PC at cycle -1.

## Configuration
- PREFETCH_UNALIGNED_EN defined: PRIME/UNALIGNED states and leftover byte present as above.
- Not defined: redirect_pc[0] and RESET_PC[0] forced 0; only ALIGNED state exists; no leftover register.

## Structure
- cpu_common package: prefetch_state_t enum (ALIGNED, PRIME, UNALIGNED); prefetch_entry_t struct {inst[15:0], pc}.
- Sub-module prefetch_fifo: DEPTH-entry circular queue with push, pop, flush, count, head outputs.

## Test plan
- Reset, RESET_PC=0x0000, ready high, memory word n = n -> reads word 0,1,2..; inst 0x0000,0x0001 with inst_pc 0x0000,0x0002; first valid 2 cycles after first strobe.
- Redirect to 0x0011, word 8=0xAABB, word 9=0xCCDD -> first inst 0xBBCC, inst_pc 0x0011, valid at t+4.
- inst_ready low 10 cycles -> at most DEPTH entries, strobe stops, no lost/duplicated instruction on resume.
- Redirect in same cycle as pop and in-flight read -> in-flight word dropped, next inst from target only.
- Odd redirect to 0x3FFF (PC_W=14), word 0x1FFF=0x1234, word 0=0x5678 -> inst 0x3456, next inst_pc 0x0001.
- Without PREFETCH_UNALIGNED_EN, redirect to 0x0011 -> fetch from 0x0010, inst_pc 0x0010.
